even_operand_issue: RTL and testbench

//  Even-pipe RF/FWD issue stage: holds the next decoded even instruction and drives its register-file read addresses.

---
 rtl/even_operand_issue_if.sv | 29 ++
 rtl/even_operand_issue.sv | 206 ++++++++++++++++++++
 tb/tb_even_operand_issue.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/even_operand_issue_if.sv
// Issue-stage input bus: one decoded even-pipe instruction plus its valid/ready handshake.
// The master drives the decoded fields; the slave is the issue stage.
interface even_operand_issue_if #(
   parameter int unsigned AW = 7
);
   logic          in_valid;
   logic          in_ready;
   logic [10:0]   in_op;
   logic [2:0]    in_format;
   logic [1:0]    in_unit;
   logic [AW-1:0] in_rt_addr;
   logic [AW-1:0] in_ra_addr;
   logic [AW-1:0] in_rb_addr;
   logic [AW-1:0] in_rc_addr;
   logic [17:0]   in_imm;
   logic          in_reg_write;

   modport master (
      output in_valid, in_op, in_format, in_unit, in_rt_addr,
      output in_ra_addr, in_rb_addr, in_rc_addr, in_imm, in_reg_write,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_format, in_unit, in_rt_addr,
      input  in_ra_addr, in_rb_addr, in_rc_addr, in_imm, in_reg_write,
      output in_ready
   );
endinterface

// File: rtl/even_operand_issue.sv
// Even-pipe RF/forwarding issue stage. Holds one decoded instruction, drives its RF read
// addresses, resolves ra/rb/rc from RF or the even/odd forwarding networks and registers the
// result into the even execution pipe. Holds across RAW stalls, drops on branch flush.
// Optional statistics counters are built when FWD_STATS_EN is defined; otherwise tied to 0.
module even_operand_issue #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned AW     = 7,
   parameter int unsigned NFW    = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   even_operand_issue_if.slave   in_if,
   output logic [AW-1:0]         rf_ra_addr_o,
   output logic [AW-1:0]         rf_rb_addr_o,
   output logic [AW-1:0]         rf_rc_addr_o,
   input  logic [DATA_W-1:0]     rf_ra_i,
   input  logic [DATA_W-1:0]     rf_rb_i,
   input  logic [DATA_W-1:0]     rf_rc_i,
   input  logic [NFW*DATA_W-1:0] ev_fw_i,
   input  logic [NFW*AW-1:0]     ev_fw_addr_i,
   input  logic [NFW-1:0]        ev_fw_wr_i,
   input  logic [NFW*DATA_W-1:0] od_fw_i,
   input  logic [NFW*AW-1:0]     od_fw_addr_i,
   input  logic [NFW-1:0]        od_fw_wr_i,
   input  logic [DATA_W-1:0]     ev_wb_i,
   input  logic [AW-1:0]         ev_wb_addr_i,
   input  logic                  ev_wb_wr_i,
   input  logic [DATA_W-1:0]     od_wb_i,
   input  logic [AW-1:0]         od_wb_addr_i,
   input  logic                  od_wb_wr_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [10:0]           op_o,
   output logic [2:0]            format_o,
   output logic [1:0]            unit_o,
   output logic [AW-1:0]         rt_addr_o,
   output logic [17:0]           imm_o,
   output logic                  reg_write_o,
   output logic [DATA_W-1:0]     ra_o,
   output logic [DATA_W-1:0]     rb_o,
   output logic [DATA_W-1:0]     rc_o,
   output logic [31:0]           fwd_hits_o,
   output logic [31:0]           stall_cycles_o
);

   typedef struct packed {
      logic [10:0]   op;
      logic [2:0]    fmt;
      logic [1:0]    unit;
      logic [AW-1:0] rt;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      logic [AW-1:0] rc;
      logic [17:0]   imm;
      logic          rw;
   } instr_t;

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e      state_q;
   instr_t      hold_q;
   instr_t      in_instr;
   instr_t      cand;
   logic        cand_valid;
   logic [DATA_W-1:0] ra_res, rb_res, rc_res;

   logic [10:0]       op_q;
   logic [2:0]        format_q;
   logic [1:0]        unit_q;
   logic [AW-1:0]     rt_addr_q;
   logic [17:0]       imm_q;
   logic              reg_write_q;
   logic [DATA_W-1:0] ra_q, rb_q, rc_q;

   // Walk oldest to youngest so the youngest match overwrites; odd after even at equal depth.
   function automatic logic [DATA_W-1:0] resolve(input logic [AW-1:0] a,
                                                 input logic [DATA_W-1:0] rf);
      logic [DATA_W-1:0] v;
      v = rf;
      if (ev_wb_wr_i && ev_wb_addr_i == a) v = ev_wb_i;
      if (od_wb_wr_i && od_wb_addr_i == a) v = od_wb_i;
      for (int i = int'(NFW) - 1; i >= 0; i--) begin
         if (ev_fw_wr_i[i] && ev_fw_addr_i[i*AW +: AW] == a) v = ev_fw_i[i*DATA_W +: DATA_W];
         if (od_fw_wr_i[i] && od_fw_addr_i[i*AW +: AW] == a) v = od_fw_i[i*DATA_W +: DATA_W];
      end
      return v;
   endfunction

   assign in_if.in_ready = (state_q == StIdle);

   // Candidate selection, RF read addresses and operand resolution.
   always_comb begin
      in_instr = '{op:   in_if.in_op,      fmt: in_if.in_format,  unit: in_if.in_unit,
                   rt:   in_if.in_rt_addr, ra:  in_if.in_ra_addr, rb:   in_if.in_rb_addr,
                   rc:   in_if.in_rc_addr, imm: in_if.in_imm,     rw:   in_if.in_reg_write};
      cand       = (state_q == StHold) ? hold_q : in_instr;
      cand_valid = (state_q == StHold) || in_if.in_valid;
      rf_ra_addr_o = cand.ra;
      rf_rb_addr_o = cand.rb;
      rf_rc_addr_o = cand.rc;
      ra_res = resolve(cand.ra, rf_ra_i);
      rb_res = resolve(cand.rb, rf_rb_i);
      rc_res = resolve(cand.rc, rf_rc_i);
   end

   // Hold/issue FSM with registered issue outputs; bubble unless a candidate issues.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         op_q        <= '0;
         format_q    <= '0;
         unit_q      <= '0;
         rt_addr_q   <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
         ra_q        <= '0;
         rb_q        <= '0;
         rc_q        <= '0;
      end else begin
         op_q        <= '0;
         format_q    <= '0;
         unit_q      <= '0;
         rt_addr_q   <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
         ra_q        <= '0;
         rb_q        <= '0;
         rc_q        <= '0;
         if (flush_i) begin
            state_q <= StIdle;
         end else if (cand_valid && stall_i) begin
            state_q <= StHold;
            hold_q  <= cand;
         end else if (cand_valid) begin
            state_q     <= StIdle;
            op_q        <= cand.op;
            format_q    <= cand.fmt;
            unit_q      <= cand.unit;
            rt_addr_q   <= cand.rt;
            imm_q       <= cand.imm;
            reg_write_q <= cand.rw;
            ra_q        <= ra_res;
            rb_q        <= rb_res;
            rc_q        <= rc_res;
         end else begin
            state_q <= StIdle;
         end
      end
   end

   assign op_o        = op_q;
   assign format_o    = format_q;
   assign unit_o      = unit_q;
   assign rt_addr_o   = rt_addr_q;
   assign imm_o       = imm_q;
   assign reg_write_o = reg_write_q;
   assign ra_o        = ra_q;
   assign rb_o        = rb_q;
   assign rc_o        = rc_q;

`ifdef FWD_STATS_EN
   logic [31:0] fwd_hits_q, stall_cycles_q;
   logic [1:0]  hit_cnt;
   logic [32:0] hits_sum, stall_sum;

   // True when a source would be taken from any forwarding or writeback entry rather than RF.
   function automatic logic fwd_hit(input logic [AW-1:0] a);
      logic h;
      h = (ev_wb_wr_i && ev_wb_addr_i == a) || (od_wb_wr_i && od_wb_addr_i == a);
      for (int i = 0; i < int'(NFW); i++) begin
         h = h || (ev_fw_wr_i[i] && ev_fw_addr_i[i*AW +: AW] == a)
               || (od_fw_wr_i[i] && od_fw_addr_i[i*AW +: AW] == a);
      end
      return h;
   endfunction

   // Saturating increments for the statistics counters.
   always_comb begin
      hit_cnt   = 2'(fwd_hit(cand.ra)) + 2'(fwd_hit(cand.rb)) + 2'(fwd_hit(cand.rc));
      hits_sum  = {1'b0, fwd_hits_q} + 33'(hit_cnt);
      stall_sum = {1'b0, stall_cycles_q} + 33'd1;
   end

   // Count forwarded sources per issue and stalled-candidate cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_hits_q     <= '0;
         stall_cycles_q <= '0;
      end else if (!flush_i && cand_valid) begin
         if (stall_i) begin
            stall_cycles_q <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
         end else begin
            fwd_hits_q <= hits_sum[32] ? 32'hFFFF_FFFF : hits_sum[31:0];
         end
      end
   end

   assign fwd_hits_o     = fwd_hits_q;
   assign stall_cycles_o = stall_cycles_q;
`else
   assign fwd_hits_o     = '0;
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_even_operand_issue.sv
// Directed bench for even_operand_issue: a per-cycle model built from the priority rules
// (score = depth*2 + even) checks every output; literal checks pin the model on key vectors.
module tb_even_operand_issue;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned AW     = 7;
   localparam int unsigned NFW    = 7;
`ifdef FWD_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic [AW-1:0]         rf_ra_addr, rf_rb_addr, rf_rc_addr;
   logic [DATA_W-1:0]     rf_ra, rf_rb, rf_rc;
   logic [NFW*DATA_W-1:0] ev_fw, od_fw;
   logic [NFW*AW-1:0]     ev_fw_addr, od_fw_addr;
   logic [NFW-1:0]        ev_fw_wr, od_fw_wr;
   logic [DATA_W-1:0]     ev_wb, od_wb;
   logic [AW-1:0]         ev_wb_addr, od_wb_addr;
   logic                  ev_wb_wr, od_wb_wr;
   logic                  stall, flush;
   logic [10:0]           op;
   logic [2:0]            format;
   logic [1:0]            unit;
   logic [AW-1:0]         rt_addr;
   logic [17:0]           imm;
   logic                  reg_write;
   logic [DATA_W-1:0]     ra, rb, rc;
   logic [31:0]           fwd_hits, stall_cycles;

   even_operand_issue_if #(.AW(AW)) bus ();

   even_operand_issue #(.DATA_W(DATA_W), .AW(AW), .NFW(NFW)) dut (
      .clk(clk), .reset(reset), .in_if(bus),
      .rf_ra_addr_o(rf_ra_addr), .rf_rb_addr_o(rf_rb_addr), .rf_rc_addr_o(rf_rc_addr),
      .rf_ra_i(rf_ra), .rf_rb_i(rf_rb), .rf_rc_i(rf_rc),
      .ev_fw_i(ev_fw), .ev_fw_addr_i(ev_fw_addr), .ev_fw_wr_i(ev_fw_wr),
      .od_fw_i(od_fw), .od_fw_addr_i(od_fw_addr), .od_fw_wr_i(od_fw_wr),
      .ev_wb_i(ev_wb), .ev_wb_addr_i(ev_wb_addr), .ev_wb_wr_i(ev_wb_wr),
      .od_wb_i(od_wb), .od_wb_addr_i(od_wb_addr), .od_wb_wr_i(od_wb_wr),
      .stall_i(stall), .flush_i(flush),
      .op_o(op), .format_o(format), .unit_o(unit), .rt_addr_o(rt_addr), .imm_o(imm),
      .reg_write_o(reg_write), .ra_o(ra), .rb_o(rb), .rc_o(rc),
      .fwd_hits_o(fwd_hits), .stall_cycles_o(stall_cycles)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [10:0] op;
      logic [2:0]  fmt;
      logic [1:0]  unit;
      logic [6:0]  rt, ra, rb, rc;
      logic [17:0] imm;
      logic        rw;
   } ins_t;

   bit           m_held = 1'b0;
   ins_t         m_h;
   ins_t         e;
   logic [127:0] e_ra, e_rb, e_rc;
   longint       m_hits = 0, m_stalls = 0;

   function automatic ins_t bus_ins();
      ins_t t;
      t.op = bus.in_op;  t.fmt = bus.in_format; t.unit = bus.in_unit; t.rt = bus.in_rt_addr;
      t.ra = bus.in_ra_addr; t.rb = bus.in_rb_addr; t.rc = bus.in_rc_addr;
      t.imm = bus.in_imm; t.rw = bus.in_reg_write;
      return t;
   endfunction

   function automatic ins_t zero_ins();
      ins_t t;
      t.op = '0; t.fmt = '0; t.unit = '0; t.rt = '0; t.ra = '0; t.rb = '0; t.rc = '0;
      t.imm = '0; t.rw = 1'b0;
      return t;
   endfunction

   // Lowest score wins: depth 1..7 (7 = writeback), odd (0) before even (1) at equal depth.
   function automatic logic [127:0] m_operand(input logic [6:0] a, input logic [127:0] rfv,
                                              output bit hit);
      int best = 1000;
      logic [127:0] v = rfv;
      hit = 1'b0;
      for (int d = 1; d <= 7; d++) begin
         for (int p = 0; p < 2; p++) begin
            logic w; logic [6:0] ad; logic [127:0] val;
            if (d == 7) begin
               w = p ? ev_wb_wr : od_wb_wr;  ad = p ? ev_wb_addr : od_wb_addr;
               val = p ? ev_wb : od_wb;
            end else begin
               w   = p ? ev_fw_wr[d] : od_fw_wr[d];
               ad  = p ? ev_fw_addr[d*AW +: AW] : od_fw_addr[d*AW +: AW];
               val = p ? ev_fw[d*DATA_W +: DATA_W] : od_fw[d*DATA_W +: DATA_W];
            end
            if (w && ad == a && d*2 + p < best) begin
               best = d*2 + p; v = val; hit = 1'b1;
            end
         end
      end
      return v;
   endfunction

   function automatic longint sat(input longint x);
      return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
   endfunction

   task automatic model_step();
      ins_t c; bit cv; bit h0, h1, h2;
      e = zero_ins(); e_ra = '0; e_rb = '0; e_rc = '0;
      if (reset) begin
         m_held = 1'b0; m_hits = 0; m_stalls = 0;
      end else if (flush) begin
         m_held = 1'b0;
      end else begin
         cv = m_held || bus.in_valid;
         c  = m_held ? m_h : bus_ins();
         if (cv && stall) begin
            m_held = 1'b1; m_h = c; m_stalls = sat(m_stalls + 1);
         end else if (cv) begin
            e = c;
            e_ra = m_operand(c.ra, rf_ra, h0);
            e_rb = m_operand(c.rb, rf_rb, h1);
            e_rc = m_operand(c.rc, rf_rc, h2);
            m_hits = sat(m_hits + int'(h0) + int'(h1) + int'(h2));
            m_held = 1'b0;
         end
      end
   endtask

   // Single compare process: RF addresses/ready mid-cycle, registered outputs after each edge.
   initial begin
      ins_t c;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("in_ready", 128'(bus.in_ready), 128'(!m_held));
            if (m_held || bus.in_valid) begin
               c = m_held ? m_h : bus_ins();
               check("rf_ra_addr", 128'(rf_ra_addr), 128'(c.ra));
               check("rf_rb_addr", 128'(rf_rb_addr), 128'(c.rb));
               check("rf_rc_addr", 128'(rf_rc_addr), 128'(c.rc));
            end
         end
         @(posedge clk);
         model_step();
         #1;
         check("op", 128'(op), 128'(e.op));
         check("format", 128'(format), 128'(e.fmt));
         check("unit", 128'(unit), 128'(e.unit));
         check("rt_addr", 128'(rt_addr), 128'(e.rt));
         check("imm", 128'(imm), 128'(e.imm));
         check("reg_write", 128'(reg_write), 128'(e.rw));
         check("ra", ra, e_ra);
         check("rb", rb, e_rb);
         check("rc", rc, e_rc);
         check("fwd_hits", 128'(fwd_hits), StatsEn ? 128'(m_hits) : 128'd0);
         check("stall_cycles", 128'(stall_cycles), StatsEn ? 128'(m_stalls) : 128'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_fwd();
      ev_fw = '0; od_fw = '0; ev_fw_addr = '0; od_fw_addr = '0; ev_fw_wr = '0; od_fw_wr = '0;
      ev_wb = '0; od_wb = '0; ev_wb_addr = '0; od_wb_addr = '0; ev_wb_wr = 1'b0; od_wb_wr = 1'b0;
   endtask

   task automatic set_fw(input bit odd, input int idx, input logic [6:0] a,
                         input logic [127:0] v);
      if (odd) begin
         od_fw[idx*DATA_W +: DATA_W] = v; od_fw_addr[idx*AW +: AW] = a; od_fw_wr[idx] = 1'b1;
      end else begin
         ev_fw[idx*DATA_W +: DATA_W] = v; ev_fw_addr[idx*AW +: AW] = a; ev_fw_wr[idx] = 1'b1;
      end
   endtask

   task automatic drive(input logic [10:0] o, input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] cc, input logic [6:0] t);
      bus.in_valid = 1'b1; bus.in_op = o; bus.in_format = 3'd3; bus.in_unit = 2'd2;
      bus.in_rt_addr = t; bus.in_ra_addr = a; bus.in_rb_addr = b; bus.in_rc_addr = cc;
      bus.in_imm = {7'h55, o}; bus.in_reg_write = 1'b1;
   endtask

   initial begin
      logic [127:0] rf_a, rf_b;
      rf_a = {32{4'hA}};
      rf_b = {32{4'hB}};
      reset = 1'b1; stall = 1'b0; flush = 1'b0; clear_fwd();
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_format = '0; bus.in_unit = '0;
      bus.in_rt_addr = '0; bus.in_ra_addr = '0; bus.in_rb_addr = '0; bus.in_rc_addr = '0;
      bus.in_imm = '0; bus.in_reg_write = 1'b0;
      rf_ra = rf_a; rf_rb = rf_b; rf_rc = {32{4'hC}};
      tick(); tick();
      check("reset_reg_write", 128'(reg_write), 128'd0);
      check("reset_in_ready", 128'(bus.in_ready), 128'd1);
      reset = 1'b0;
      tick();

      // No hazard: operands straight from RF.
      drive(11'h123, 7'd5, 7'd6, 7'd7, 7'd10);
      tick();
      check("t1_ra", ra, rf_a);
      check("t1_reg_write", 128'(reg_write), 128'd1);
      check("t1_in_ready", 128'(bus.in_ready), 128'd1);

      // Odd beats even at equal depth; shallower depth beats deeper.
      drive(11'h124, 7'd9, 7'd1, 7'd2, 7'd11);
      set_fw(1'b0, 2, 7'd9, 128'h1111);
      set_fw(1'b1, 2, 7'd9, 128'h2222);
      set_fw(1'b0, 5, 7'd9, 128'h5555);
      tick();
      check("t2_ra", ra, 128'h2222);
      set_fw(1'b0, 1, 7'd9, 128'h7777);
      set_fw(1'b1, 3, 7'd9, 128'h3333);
      tick();
      check("t2b_ra", ra, 128'h7777);
      bus.in_valid = 1'b0; clear_fwd();
      tick();

      // Stall three cycles; forwarding appears during hold and is picked up on release.
      rf_ra = 128'hF0;
      drive(11'h200, 7'd20, 7'd3, 7'd4, 7'd12);
      stall = 1'b1;
      tick();
      check("t3_bubble", 128'(reg_write), 128'd0);
      check("t3_in_ready", 128'(bus.in_ready), 128'd0);
      drive(11'h201, 7'd21, 7'd3, 7'd4, 7'd13);
      set_fw(1'b0, 4, 7'd20, 128'hBEEF);
      tick(); tick();
      stall = 1'b0;
      tick();
      check("t3_ra", ra, 128'hBEEF);
      check("t3_op", 128'(op), 128'h200);
      check("t3_stalls", 128'(stall_cycles), StatsEn ? 128'd3 : 128'd0);
      check("t3_hits", 128'(fwd_hits), StatsEn ? 128'd3 : 128'd0);
      tick();
      check("t3_next_op", 128'(op), 128'h201);
      bus.in_valid = 1'b0; clear_fwd(); rf_ra = rf_a;
      tick();

      // Flush during hold drops the held instruction and the same-cycle input.
      drive(11'h300, 7'd8, 7'd3, 7'd4, 7'd14);
      stall = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0; bus.in_valid = 1'b0;
      check("t4_bubble", 128'(reg_write), 128'd0);
      check("t4_in_ready", 128'(bus.in_ready), 128'd1);
      tick();
      check("t4_no_issue", 128'(op), 128'd0);

      // Writeback-only hit on the odd side, then disabled.
      drive(11'h400, 7'd30, 7'd127, 7'd31, 7'd15);
      od_wb = 128'hCAFE; od_wb_addr = 7'd127; od_wb_wr = 1'b1;
      tick();
      check("t5_rb_wb", rb, 128'hCAFE);
      od_wb_wr = 1'b0;
      tick();
      check("t5_rb_rf", rb, rf_b);
      bus.in_valid = 1'b0; clear_fwd();
      tick();

      // Reset while holding under stall.
      drive(11'h500, 7'd40, 7'd41, 7'd42, 7'd16);
      stall = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check("t6_op", 128'(op), 128'd0);
      check("t6_ra", ra, 128'd0);
      check("t6_in_ready", 128'(bus.in_ready), 128'd1);
      check("t6_stalls", 128'(stall_cycles), 128'd0);
      check("t6_hits", 128'(fwd_hits), 128'd0);
      reset = 1'b0; stall = 1'b0; bus.in_valid = 1'b0;
      tick();
      check("t6_no_issue", 128'(reg_write), 128'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
